// File: rtl/baud_gen_frac.sv
// rtl/baud_gen_frac.sv - fractional baud generator with programmable oversampling ratio
//
// Produces a single-cycle oversample strobe (rx_tick) and a bit strobe
// (tx_tick) from an integer + fractional divisor. Configuration writes are
// staged in a shadow copy and only take effect on an rx_tick boundary, so no
// runt or stretched period is ever emitted.
//
// Optional feature macro: BAUD_GEN_MID_TICK_EN (adds o_mid_tick, the
// bit-centre strobe for receiver sampling).
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   i_en           generator enable; low holds all phase state at zero
//   i_divisor      integer clocks per rx_tick (values below 2 clamp to 2)
//   i_frac         fractional clocks per rx_tick, units of 1/2^FRAC_W
//   i_osr          rx_ticks per tx_tick (values below 4 clamp to 4)
//   i_cfg_load     one-cycle pulse capturing i_divisor/i_frac/i_osr
//   rx_tick        one-cycle oversample strobe
//   tx_tick        one-cycle bit strobe, always coincident with rx_tick
//   o_cfg_pending  a captured configuration awaits the next rx_tick
//   o_mid_tick     (BAUD_GEN_MID_TICK_EN only) bit-centre strobe

module baud_gen_frac #(
    parameter int DIV_W   = 16,
    parameter int FRAC_W  = 4,
    parameter int OSR_W   = 5,
    parameter int DEF_DIV = 325,
    parameter int DEF_OSR = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic [DIV_W-1:0]  i_divisor,
    input  logic [FRAC_W-1:0] i_frac,
    input  logic [OSR_W-1:0]  i_osr,
    input  logic              i_cfg_load,
    output logic              rx_tick,
    output logic              tx_tick,
    output logic              o_cfg_pending
`ifdef BAUD_GEN_MID_TICK_EN
    ,
    output logic              o_mid_tick
`endif
);

    localparam logic [DIV_W-1:0] DEF_DIV_C = DIV_W'(DEF_DIV);
    localparam logic [OSR_W-1:0] DEF_OSR_C = OSR_W'(DEF_OSR);
    localparam logic [DIV_W:0]   PERIOD_ONE = (DIV_W+1)'(1);
    localparam logic [OSR_W-1:0] OSR_ONE   = OSR_W'(1);

    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        return (d < DIV_W'(2)) ? DIV_W'(2) : d;
    endfunction

    function automatic logic [OSR_W-1:0] clamp_osr(input logic [OSR_W-1:0] o);
        return (o < OSR_W'(4)) ? OSR_W'(4) : o;
    endfunction

    // Active configuration (already clamped)
    logic [DIV_W-1:0]  div_q,  div_d;
    logic [FRAC_W-1:0] frac_q, frac_d;
    logic [OSR_W-1:0]  osr_q,  osr_d;

    // Shadow configuration (raw, clamped when it becomes active)
    logic [DIV_W-1:0]  sh_div_q,  sh_div_d;
    logic [FRAC_W-1:0] sh_frac_q, sh_frac_d;
    logic [OSR_W-1:0]  sh_osr_q,  sh_osr_d;
    logic              pend_q,    pend_d;

    // Phase state
    logic [DIV_W:0]    div_cnt_q,  div_cnt_d;
    logic [OSR_W-1:0]  osr_cnt_q,  osr_cnt_d;
    logic [FRAC_W-1:0] frac_acc_q, frac_acc_d;
    logic              carry_q,    carry_d;

    logic [DIV_W:0]    period;
    logic [FRAC_W:0]   frac_sum;
    logic              osr_last;

    // A carry out of the accumulator stretches the following period by one
    // clock; over 2^FRAC_W ticks this spreads exactly frac extra clocks.
    assign period   = {1'b0, div_q} + {{DIV_W{1'b0}}, carry_q};
    assign frac_sum = {1'b0, frac_acc_q} + {1'b0, frac_q};
    assign osr_last = (osr_cnt_q == osr_q - OSR_ONE);

    // i_en gates the strobe so a tick can never leak in the cycle enable drops
    assign rx_tick       = i_en && (div_cnt_q == period - PERIOD_ONE);
    assign tx_tick       = rx_tick && osr_last;
    assign o_cfg_pending = pend_q;

`ifdef BAUD_GEN_MID_TICK_EN
    assign o_mid_tick = rx_tick && (osr_cnt_q == (osr_q >> 1) - OSR_ONE);
`endif

    always_comb begin
        div_d      = div_q;
        frac_d     = frac_q;
        osr_d      = osr_q;
        sh_div_d   = sh_div_q;
        sh_frac_d  = sh_frac_q;
        sh_osr_d   = sh_osr_q;
        pend_d     = pend_q;
        div_cnt_d  = div_cnt_q;
        osr_cnt_d  = osr_cnt_q;
        frac_acc_d = frac_acc_q;
        carry_d    = carry_q;

        if (!i_en) begin
            div_cnt_d  = '0;
            osr_cnt_d  = '0;
            frac_acc_d = '0;
            carry_d    = 1'b0;
            // Nothing is ticking, so there is no boundary to wait for
            if (i_cfg_load) begin
                div_d  = clamp_div(i_divisor);
                frac_d = i_frac;
                osr_d  = clamp_osr(i_osr);
                pend_d = 1'b0;
            end
        end else begin
            if (i_cfg_load) begin
                sh_div_d  = i_divisor;
                sh_frac_d = i_frac;
                sh_osr_d  = i_osr;
                pend_d    = 1'b1;
            end
            if (rx_tick) begin
                div_cnt_d = '0;
                // A load landing on the tick itself is held for the next
                // boundary; the current boundary finishes on the old config.
                if (pend_q && !i_cfg_load) begin
                    div_d      = clamp_div(sh_div_q);
                    frac_d     = sh_frac_q;
                    osr_d      = clamp_osr(sh_osr_q);
                    pend_d     = 1'b0;
                    frac_acc_d = '0;
                    carry_d    = 1'b0;
                    osr_cnt_d  = '0;
                end else begin
                    frac_acc_d = frac_sum[FRAC_W-1:0];
                    carry_d    = frac_sum[FRAC_W];
                    osr_cnt_d  = osr_last ? '0 : osr_cnt_q + OSR_ONE;
                end
            end else begin
                div_cnt_d = div_cnt_q + PERIOD_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q      <= DEF_DIV_C;
            frac_q     <= '0;
            osr_q      <= DEF_OSR_C;
            sh_div_q   <= '0;
            sh_frac_q  <= '0;
            sh_osr_q   <= '0;
            pend_q     <= 1'b0;
            div_cnt_q  <= '0;
            osr_cnt_q  <= '0;
            frac_acc_q <= '0;
            carry_q    <= 1'b0;
        end else begin
            div_q      <= div_d;
            frac_q     <= frac_d;
            osr_q      <= osr_d;
            sh_div_q   <= sh_div_d;
            sh_frac_q  <= sh_frac_d;
            sh_osr_q   <= sh_osr_d;
            pend_q     <= pend_d;
            div_cnt_q  <= div_cnt_d;
            osr_cnt_q  <= osr_cnt_d;
            frac_acc_q <= frac_acc_d;
            carry_q    <= carry_d;
        end
    end

endmodule

// File: tb/tb_baud_gen_frac.sv
// tb/tb_baud_gen_frac.sv - self-checking bench for baud_gen_frac
module tb_baud_gen_frac;

    localparam int DIV_W  = 16;
    localparam int FRAC_W = 4;
    localparam int OSR_W  = 5;
    localparam int FSCALE = 1 << FRAC_W;

    logic              clk;
    logic              rst_n;
    logic              i_en;
    logic [DIV_W-1:0]  i_divisor;
    logic [FRAC_W-1:0] i_frac;
    logic [OSR_W-1:0]  i_osr;
    logic              i_cfg_load;
    logic              rx_tick;
    logic              tx_tick;
    logic              o_cfg_pending;
`ifdef BAUD_GEN_MID_TICK_EN
    logic              o_mid_tick;
`endif

    baud_gen_frac dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_en          (i_en),
        .i_divisor     (i_divisor),
        .i_frac        (i_frac),
        .i_osr         (i_osr),
        .i_cfg_load    (i_cfg_load),
        .rx_tick       (rx_tick),
        .tx_tick       (tx_tick),
        .o_cfg_pending (o_cfg_pending)
`ifdef BAUD_GEN_MID_TICK_EN
        ,
        .o_mid_tick    (o_mid_tick)
`endif
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: within a segment (started by enable, reset or a config
    // apply) the m-th tick lands after m*div + floor((m-1)*frac/2^F) clocks.
    int  m_div, m_frac, m_osr;
    int  s_div, s_frac, s_osr;
    bit  m_pend;
    int  m_cyc, m_n;
    int  cyc_no;

    int  rx_hist[$];
    bit  tx_hist[$];
    bit  mid_hist[$];

    function automatic int t_of(input int m);
        return m * m_div + ((m - 1) * m_frac) / FSCALE;
    endfunction

    function automatic int cl_div(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    function automatic int cl_osr(input int o);
        return (o < 4) ? 4 : o;
    endfunction

    task automatic model_reset();
        m_div = 325; m_frac = 0; m_osr = 16;
        m_pend = 1'b0; m_cyc = 0; m_n = 0;
    endtask

    task automatic clear_hist();
        rx_hist.delete();
        tx_hist.delete();
        mid_hist.delete();
    endtask

    // One clock: drive inputs just after negedge, compare, advance the model.
    task automatic step(input bit en, input bit load, input int d, input int f, input int o);
        bit exp_rx, exp_tx;
        i_en       = en;
        i_cfg_load = load;
        i_divisor  = d[DIV_W-1:0];
        i_frac     = f[FRAC_W-1:0];
        i_osr      = o[OSR_W-1:0];
        #1;
        exp_rx = en && (m_cyc + 1 == t_of(m_n + 1));
        exp_tx = exp_rx && (((m_n + 1) % m_osr) == 0);
        check("ticks_rx_tx_pend", {29'd0, rx_tick, tx_tick, o_cfg_pending},
              {29'd0, exp_rx, exp_tx, m_pend});
`ifdef BAUD_GEN_MID_TICK_EN
        check("mid_tick", {31'd0, o_mid_tick},
              {31'd0, exp_rx && (((m_n + 1) % m_osr) == m_osr / 2)});
`endif
        if (rx_tick) begin
            rx_hist.push_back(cyc_no);
            tx_hist.push_back(tx_tick);
`ifdef BAUD_GEN_MID_TICK_EN
            mid_hist.push_back(o_mid_tick);
`endif
        end
        @(posedge clk);
        if (!en) begin
            m_cyc = 0; m_n = 0;
            if (load) begin
                m_div = cl_div(d); m_frac = f; m_osr = cl_osr(o); m_pend = 1'b0;
            end
        end else if (exp_rx && m_pend && !load) begin
            m_div = cl_div(s_div); m_frac = s_frac; m_osr = cl_osr(s_osr);
            m_pend = 1'b0; m_cyc = 0; m_n = 0;
        end else begin
            m_cyc++;
            if (exp_rx) m_n++;
            if (load) begin
                s_div = d; s_frac = f; s_osr = o; m_pend = 1'b1;
            end
        end
        cyc_no++;
        @(negedge clk);
        i_cfg_load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
    endtask

    task automatic wait_apply(input string tag);
        int k = 0;
        while (m_pend && k < 4000) begin
            step(1, 0, 0, 0, 0);
            k++;
        end
        check(tag, {31'd0, o_cfg_pending}, 32'd0);
    endtask

    task automatic run_ticks(input string tag, input int k);
        int start = rx_hist.size();
        int c = 0;
        while (rx_hist.size() - start < k && c < 20000) begin
            step(1, 0, 0, 0, 0);
            c++;
        end
        check(tag, rx_hist.size() - start, k);
    endtask

    function automatic int count_tx();
        int c = 0;
        foreach (tx_hist[i]) if (tx_hist[i]) c++;
        return c;
    endfunction

    initial begin
        int lcyc, d, f, o, tmp;

        rst_n = 1'b0; i_en = 1'b1; i_cfg_load = 1'b0;
        i_divisor = '0; i_frac = '0; i_osr = '0;
        cyc_no = 0;
        s_div = 0; s_frac = 0; s_osr = 0;
        model_reset();

        // TC_01: 200 ns of reset, then default 325-clock rx period
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (i == 3 || i == 9)
                check("tc01_reset_outs", {29'd0, rx_tick, tx_tick, o_cfg_pending}, 32'd0);
        end
        rst_n = 1'b1;
        cyc_no = 0;
        clear_hist();
        run_ticks("tc01_timeout", 2);
        check("tc01_first_tick_clk", rx_hist[0] + 1, 325);
        check("tc01_period_ns", (rx_hist[1] - rx_hist[0]) * 20, 6500);

        // TC_02: 27 + 2/16 -> any 8 periods sum to 217 clocks
        step(1, 1, 27, 2, 16);
        wait_apply("tc02_applied");
        clear_hist();
        run_ticks("tc02_timeout", 12);
        check("tc02_8per_ns_a", (rx_hist[8] - rx_hist[0]) * 20, 4340);
        check("tc02_8per_ns_b", (rx_hist[11] - rx_hist[3]) * 20, 4340);
        check("tc02_short_per", rx_hist[1] - rx_hist[0], 27);

        // TC_03: osr 16 then osr 8 at div=10
        step(1, 1, 10, 0, 16);
        wait_apply("tc03_applied16");
        clear_hist();
        run_ticks("tc03_timeout16", 32);
        check("tc03_tx_cnt16", count_tx(), 2);
        check("tc03_tx_pos16", {30'd0, tx_hist[15], tx_hist[31]}, 32'd3);
        step(1, 1, 10, 0, 8);
        wait_apply("tc03_applied8");
        clear_hist();
        run_ticks("tc03_timeout8", 16);
        check("tc03_tx_cnt8", count_tx(), 2);
        check("tc03_tx_pos8", {30'd0, tx_hist[7], tx_hist[15]}, 32'd3);

        // TC_04: staged load mid-period
        step(1, 1, 100, 0, 16);
        wait_apply("tc04_applied100");
        idle(30);
        lcyc = cyc_no;
        clear_hist();
        step(1, 1, 50, 0, 16);
        #1;
        check("tc04_pending_set", {31'd0, o_cfg_pending}, 32'd1);
        run_ticks("tc04_timeout", 2);
        check("tc04_old_period_end", rx_hist[0] - lcyc, 69);
        check("tc04_new_period", rx_hist[1] - rx_hist[0], 50);

        // TC_05: clamp and enable handling
        step(1, 1, 0, 0, 1);
        wait_apply("tc05_applied");
        clear_hist();
        run_ticks("tc05_timeout", 8);
        check("tc05_clamp_period", rx_hist[1] - rx_hist[0], 2);
        check("tc05_clamp_tx", count_tx(), 2);
        tmp = rx_hist.size();
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
        check("tc05_disabled_ticks", rx_hist.size() - tmp, 0);
        lcyc = cyc_no;
        clear_hist();
        run_ticks("tc05_reen_timeout", 1);
        check("tc05_reen_first", rx_hist[0] - lcyc + 1, 2);
        step(0, 1, 40, 3, 6);
        step(0, 0, 0, 0, 0);
        lcyc = cyc_no;
        clear_hist();
        run_ticks("tc05_dis_load_timeout", 1);
        check("tc05_dis_load_first", rx_hist[0] - lcyc + 1, 40);

        // TC_06: random configurations, some loaded while disabled
        for (int it = 0; it < 20; it++) begin
            d = int'($urandom_range(500, 10));
            f = int'($urandom_range(15, 0));
            o = int'($urandom_range(16, 4));
            if (it % 5 == 4) begin
                step(0, 1, d, f, o);
                step(0, 0, 0, 0, 0);
            end else begin
                step(1, 1, d, f, o);
                wait_apply("tc06_applied");
            end
            clear_hist();
            run_ticks("tc06_timeout", 8);
            check("tc06_avg_7per", rx_hist[7] - rx_hist[0], 7 * d + (7 * f) / FSCALE);
        end

`ifdef BAUD_GEN_MID_TICK_EN
        step(1, 1, 10, 0, 16);
        wait_apply("tc06_mid_applied");
        clear_hist();
        run_ticks("tc06_mid_timeout", 32);
        tmp = 0;
        foreach (mid_hist[i]) if (mid_hist[i]) tmp++;
        check("tc06_mid_cnt", tmp, 2);
        check("tc06_mid_pos", {30'd0, mid_hist[7], mid_hist[23]}, 32'd3);
`endif

        // Reset mid-operation discards a pending config
        step(1, 1, 20, 0, 4);
        #5;
        rst_n = 1'b0;
        #1;
        check("rst_async_outs", {29'd0, rx_tick, tx_tick, o_cfg_pending}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        lcyc = cyc_no;
        clear_hist();
        run_ticks("rst_timeout", 2);
        check("rst_default_first", rx_hist[0] - lcyc + 1, 325);
        check("rst_default_period", rx_hist[1] - rx_hist[0], 325);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
